// File: rtl/word_aligner_pkg.sv
// Shared constants and types for the 10-bit word aligner and its comma detector.
package word_aligner_pkg;

    localparam int WORD_W  = 10;
    localparam int PHASE_W = 4;
    localparam int CNT_W   = 16;

    // Bit position of the last bit of a word; a bit_en cycle at this phase is a boundary.
    localparam logic [PHASE_W-1:0] PHASE_LAST = 4'd9;
    // Fill counter saturation value: a full window has been received.
    localparam logic [PHASE_W-1:0] FILL_FULL  = 4'd10;

    // The line comma flagged by comma_detector.
    localparam logic [WORD_W-1:0] COMMA_PAT = 10'b1010001110;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Advance a bit position by one, wrapping after the last bit of a word.
    function automatic logic [PHASE_W-1:0] phase_inc(input logic [PHASE_W-1:0] p);
        return (p == PHASE_LAST) ? '0 : p + 4'd1;
    endfunction

endpackage

// File: rtl/comma_detector.sv
// Combinational comma detector: flags a 10-bit window equal to the line comma.
module comma_detector
    import word_aligner_pkg::*;
(
    input  logic [WORD_W-1:0] pi,
    output logic              det
);

    assign det = (pi == COMMA_PAT);

endmodule

// File: rtl/word_aligner.sv
// Serial-to-parallel word aligner: hunts for commas, verifies a consistent
// word phase, then emits aligned 10-bit words with a one-cycle valid strobe.
module word_aligner
    import word_aligner_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4,
    parameter int MAX_GAP    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              comma_out,
    output logic              locked,
    output logic              align_err
);

    localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] LOSS_C  = CNT_W'(LOSS_COUNT);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(MAX_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               GAP_EN  = (MAX_GAP != 0);

    logic [WORD_W-1:0]  win_q,   win_d;
    logic [PHASE_W-1:0] fill_q,  fill_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   good_q,  good_d;
    logic [CNT_W-1:0]   miss_q,  miss_d;
    logic [CNT_W-1:0]   gap_q,   gap_d;
    logic [WORD_W-1:0]  word_q,  word_d;
    logic               valid_q, valid_d;
    logic               comma_q, comma_d;
    logic               locked_q, locked_d;
    logic               err_q,   err_d;

    logic [WORD_W-1:0]  win_next;
    logic               det_raw;
    logic               qdet;
    logic               boundary;

    // The detector looks at the window as it will be after this cycle's shift.
    assign win_next = {win_q[WORD_W-2:0], bit_in};

    comma_detector u_comma_detector (
        .pi  (win_next),
        .det (det_raw)
    );

    // A detection only counts on a shift cycle once ten bits have arrived since reset.
    assign qdet     = bit_en && det_raw && (fill_q >= (FILL_FULL - 4'd1));
    assign boundary = bit_en && (phase_q == PHASE_LAST);

    // Next-state logic: shift/fill/phase tracking plus the HUNT/VERIFY/LOCKED FSM.
    always_comb begin
        win_d    = win_q;
        fill_d   = fill_q;
        phase_d  = phase_q;
        state_d  = state_q;
        good_d   = good_q;
        miss_d   = miss_q;
        gap_d    = gap_q;
        word_d   = word_q;
        comma_d  = comma_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (bit_en) begin
            win_d   = win_next;
            fill_d  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 4'd1;
            phase_d = phase_inc(phase_q);
        end

        unique case (state_q)
            ST_HUNT: begin
                // A comma marks the current bit as the end of a word.
                if (qdet) begin
                    phase_d = '0;
                    good_d  = CNT_ONE;
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (boundary) begin
                    if (qdet) begin
                        good_d = good_q + CNT_ONE;
                        if (good_d >= LOCK_C) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                            gap_d   = '0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end else if (qdet) begin
                    // Comma at a different phase: restart verification there.
                    phase_d = '0;
                    good_d  = CNT_ONE;
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    word_d  = win_next;
                    comma_d = qdet;
                    valid_d = 1'b1;
                    if (qdet) begin
                        miss_d = '0;
                        gap_d  = '0;
                    end else begin
                        gap_d = gap_q + CNT_ONE;
                    end
                end else if (qdet) begin
                    miss_d = miss_q + CNT_ONE;
                end
                // Either loss condition (or both) yields a single error pulse.
                if ((miss_d >= LOSS_C) || (GAP_EN && (gap_d >= GAP_C))) begin
                    state_d = ST_HUNT;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q    <= '0;
            fill_q   <= '0;
            phase_q  <= '0;
            state_q  <= ST_HUNT;
            good_q   <= '0;
            miss_q   <= '0;
            gap_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            comma_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            win_q    <= win_d;
            fill_q   <= fill_d;
            phase_q  <= phase_d;
            state_q  <= state_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            gap_q    <= gap_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            comma_q  <= comma_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign comma_out  = comma_q;
    assign locked     = locked_q;
    assign align_err  = err_q;

endmodule

// File: tb/tb_word_aligner.sv
// Bench for word_aligner: directed word table, hand-written corner sequences
// and a randomized stream checked cycle by cycle against a bit-index model.
module tb_word_aligner;
    import word_aligner_pkg::*;

    localparam logic [9:0] C = 10'b1010001110;
    localparam logic [9:0] D = 10'b0000000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_en = 1'b0;
    logic [9:0] wo_a, wo_g;
    logic       wv_a, co_a, lk_a, ae_a;
    logic       wv_g, co_g, lk_g, ae_g;
    logic [9:0] cd_pi;
    logic       cd_det;

    word_aligner #(.LOCK_COUNT(3), .LOSS_COUNT(4), .MAX_GAP(64)) dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .word_out(wo_a), .word_valid(wv_a), .comma_out(co_a),
        .locked(lk_a), .align_err(ae_a));

    word_aligner #(.LOCK_COUNT(3), .LOSS_COUNT(4), .MAX_GAP(4)) dut_g (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .word_out(wo_g), .word_valid(wv_g), .comma_out(co_g),
        .locked(lk_g), .align_err(ae_g));

    comma_detector u_cd (.pi(cd_pi), .det(cd_det));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: tracks the absolute index of every received bit and the
    // index of the last anchoring comma; a boundary is any bit a whole number
    // of words after the anchor.
    typedef struct {
        int         mode;     // 0 hunt, 1 verify, 2 locked
        int         nbits;
        int         anchor;
        int         good;
        int         miss;
        int         gap;
        logic [9:0] win;
        bit         v;
        logic [9:0] w;
        bit         c;
        bit         lk;
        bit         er;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t s;
        s.mode = 0; s.nbits = 0; s.anchor = -1; s.good = 0; s.miss = 0; s.gap = 0;
        s.win = '0; s.v = 1'b0; s.w = '0; s.c = 1'b0; s.lk = 1'b0; s.er = 1'b0;
        return s;
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input bit r, input bit en, input bit b,
                                   input int maxgap);
        mdl_t n;
        int   i;
        bit   det;
        bit   bnd;
        if (r) return mreset();
        n = s;
        n.v = 1'b0;
        n.er = 1'b0;
        if (!en) return n;
        i = s.nbits;
        n.nbits = s.nbits + 1;
        n.win = {s.win[8:0], b};
        det = (i >= 9) && (n.win == C);
        bnd = (((i - s.anchor) % 10) == 0);
        case (s.mode)
            0: if (det) begin n.anchor = i; n.good = 1; n.mode = 1; end
            1: begin
                if (bnd) begin
                    if (det) begin
                        n.good = s.good + 1;
                        if (n.good >= 3) begin n.mode = 2; n.miss = 0; n.gap = 0; end
                    end else n.mode = 0;
                end else if (det) begin
                    n.anchor = i; n.good = 1;
                end
            end
            default: begin
                if (bnd) begin
                    n.v = 1'b1; n.w = n.win; n.c = det;
                    if (det) begin n.miss = 0; n.gap = 0; end
                    else n.gap = s.gap + 1;
                end else if (det) n.miss = s.miss + 1;
                if (n.miss >= 4 || (maxgap != 0 && n.gap >= maxgap)) begin
                    n.mode = 0; n.er = 1'b1;
                end
            end
        endcase
        n.lk = (n.mode == 2);
        return n;
    endfunction

    mdl_t ma, mg;

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic tick(input bit r, input bit en, input bit b);
        @(negedge clk);
        rst = r; bit_en = en; bit_in = b;
        ma = mstep(ma, r, en, b, 64);
        mg = mstep(mg, r, en, b, 4);
        @(posedge clk);
        #1;
        chk("mdl_a_ctl", {29'b0, wv_a, lk_a, ae_a}, {29'b0, ma.v, ma.lk, ma.er});
        if (ma.v) chk("mdl_a_word", {21'b0, co_a, wo_a}, {21'b0, ma.c, ma.w});
        chk("mdl_g_ctl", {29'b0, wv_g, lk_g, ae_g}, {29'b0, mg.v, mg.lk, mg.er});
        if (mg.v) chk("mdl_g_word", {21'b0, co_g, wo_g}, {21'b0, mg.c, mg.w});
    endtask

    task automatic send_word(input logic [9:0] w, input int nb, input bit gp);
        for (int k = nb - 1; k >= 0; k--) begin
            tick(1'b0, 1'b1, w[k]);
            if (gp && k != 0) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        logic [9:0] w;
        int         nb;
        bit         gp;
        bit         rs;
        int         ds;
        bit         ev;
        logic [9:0] ew;
        bit         ec;
        bit         el;
        bit         ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [9:0] w, input int nb, input bit gp, input bit rs,
                       input int ds, input bit ev, input logic [9:0] ew, input bit ec,
                       input bit el, input bit ee);
        vec_t v;
        v.w = w; v.nb = nb; v.gp = gp; v.rs = rs; v.ds = ds;
        v.ev = ev; v.ew = ew; v.ec = ec; v.el = el; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic lock_group(input bit gp);
        add(D, 10, gp, 1, 0, 0, D, 0, 0, 0);
        add(C, 10, gp, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, gp, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, gp, 0, 0, 0, D, 0, 1, 0);
        add(D, 10, gp, 0, 0, 1, D, 0, 1, 0);
        add(C, 10, gp, 0, 0, 1, C, 1, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic       v, l, e, c;
        logic [9:0] w;
        logic [19:0] pair;
        logic [9:0]  pa [4];
        logic [9:0]  pb [4];

        ma = mreset();
        mg = mreset();

        // Reset state.
        tick(1'b1, 1'b0, 1'b0);
        chk("reset_outputs", {19'b0, wo_a, wv_a, co_a, lk_a, ae_a}, 32'd0);

        // Filler words never form a comma in any window; C itself does.
        pa[0] = D; pb[0] = D; pa[1] = D; pb[1] = C;
        pa[2] = C; pb[2] = D; pa[3] = C; pb[3] = C;
        cd_pi = C; #1;
        chk("det_on_comma", {31'b0, cd_det}, 32'd1);
        for (int p = 0; p < 4; p++) begin
            pair = {pa[p], pb[p]};
            for (int k = 0; k < 10; k++) begin
                if (k == 0 && pa[p] == C) continue;
                cd_pi = 10'(pair >> (10 - k));
                #1;
                chk($sformatf("filler_window_p%0d_k%0d", p, k), {31'b0, cd_det}, 32'd0);
            end
        end

        // Lock, emit, misalignment loss, relock.
        lock_group(1'b0);
        add(D, 10, 0, 0, 0, 1, D, 0, 1, 0);
        add(D, 3,  0, 0, 0, 0, D, 0, 1, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 1, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 1, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 1, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 0, 1);
        add(C, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 1, 0);
        add(D, 10, 0, 0, 0, 1, D, 0, 1, 0);
        // Verify failure: VERIFY drops back on a comma-less boundary.
        add(D, 10, 0, 1, 0, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(D, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(D, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(D, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 0, 0, D, 0, 1, 0);
        // Gap timeout on the MAX_GAP=4 instance.
        add(D, 10, 0, 1, 1, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 1, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 1, 0, D, 0, 0, 0);
        add(C, 10, 0, 0, 1, 0, D, 0, 1, 0);
        add(D, 10, 0, 0, 1, 1, D, 0, 1, 0);
        add(D, 10, 0, 0, 1, 1, D, 0, 1, 0);
        add(D, 10, 0, 0, 1, 1, D, 0, 1, 0);
        add(D, 10, 0, 0, 1, 1, D, 0, 0, 1);
        // Lock scenario again with bit_en toggling.
        lock_group(1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) tick(1'b1, 1'b0, 1'b0);
            send_word(tbl[i].w, tbl[i].nb, tbl[i].gp);
            if (tbl[i].ds == 0) begin v = wv_a; l = lk_a; e = ae_a; c = co_a; w = wo_a; end
            else begin v = wv_g; l = lk_g; e = ae_g; c = co_g; w = wo_g; end
            chk($sformatf("row%0d_valid", i), {31'b0, v}, {31'b0, tbl[i].ev});
            chk($sformatf("row%0d_locked", i), {31'b0, l}, {31'b0, tbl[i].el});
            chk($sformatf("row%0d_err", i), {31'b0, e}, {31'b0, tbl[i].ee});
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_word", i), {22'b0, w}, {22'b0, tbl[i].ew});
                chk($sformatf("row%0d_comma", i), {31'b0, c}, {31'b0, tbl[i].ec});
            end
            if (tbl[i].gp) begin
                tick(1'b0, 1'b0, 1'b0);
                if (tbl[i].ds == 0) begin v = wv_a; e = ae_a; end
                else begin v = wv_g; e = ae_g; end
                chk($sformatf("row%0d_pulse_width", i), {30'b0, v, e}, 32'd0);
            end
        end

        // Reset mid-word while locked, five bits into a word.
        send_word(D, 5, 1'b0);
        chk("midrst_pre_locked", {31'b0, lk_a}, 32'd1);
        tick(1'b1, 1'b1, 1'b1);
        chk("midrst_outputs_a", {19'b0, wo_a, wv_a, co_a, lk_a, ae_a}, 32'd0);
        chk("midrst_outputs_g", {19'b0, wo_g, wv_g, co_g, lk_g, ae_g}, 32'd0);
        send_word(C, 9, 1'b0);
        chk("midrst_partial_locked", {31'b0, lk_a}, 32'd0);
        send_word(C, 10, 1'b0);
        send_word(C, 10, 1'b0);
        chk("midrst_two_commas_locked", {31'b0, lk_a}, 32'd0);
        send_word(C, 10, 1'b0);
        chk("midrst_relock", {31'b0, lk_a}, 32'd1);

        // Randomized stream: commas, filler, random words, slips, gaps, resets.
        for (int wi = 0; wi < 700; wi++) begin
            int         r;
            int         nb;
            logic [9:0] rw;
            r = int'($urandom_range(0, 39));
            nb = 10;
            if (r == 0) begin
                tick(1'b1, 1'b0, 1'b0);
                continue;
            end
            if (r < 16) rw = C;
            else if (r < 26) rw = D;
            else if (r < 34) rw = 10'($urandom);
            else begin
                nb = int'($urandom_range(1, 3));
                rw = 10'($urandom);
            end
            for (int k = nb - 1; k >= 0; k--) begin
                if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                tick(1'b0, 1'b1, rw[k]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
